// File: rtl/dm_pkg.sv
// Debug-module shared types plus JTAG host scan constants and helpers.
// Used by dmi_jtag_host (optional TRST via DMI_JTAG_HOST_TRST_EN).
package dm;

  localparam logic [4:0] DtmIrDmiAccess = 5'h11;
  localparam logic [4:0] DtmIrDtmcs = 5'h10;
  localparam int unsigned DmiScanWidth = 41;
  localparam int unsigned DtmcsDmiResetBit = 16;

  localparam logic [1:0] DtmNop = 2'd0;
  localparam logic [1:0] DtmRead = 2'd1;
  localparam logic [1:0] DtmWrite = 2'd2;
  localparam logic [1:0] DtmBusy = 2'd3;

  typedef struct packed {
    logic [6:0]  addr;
    logic [31:0] data;
    logic [1:0]  op;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

  typedef struct packed {
    logic [6:0]  addr;
    logic [31:0] data;
    logic [1:0]  op;
  } dmi_scan_t;

  typedef enum logic [3:0] {
    StTrst,
    StTapReset,
    StSelIr,
    StIdle,
    StAccess,
    StRunIdle,
    StStatus,
    StRstIr,
    StRstDr,
    StRstSel,
    StRespond
  } host_state_e;

  // TMS stream from Run-Test/Idle through n shift bits back to Run-Test/Idle
  function automatic logic [63:0] scan_tms(
    input logic       ir,
    input logic [5:0] n
  );
    logic [63:0] v;
    logic [5:0]  s;
    s = ir ? 6'd4 : 6'd3;
    v = 64'd1;
    v[1] = ir;
    v[6'(s + n - 6'd1)] = 1'b1;
    v[6'(s + n)] = 1'b1;
    return v;
  endfunction

  function automatic logic [63:0] scan_tdi(
    input logic        ir,
    input logic [63:0] d
  );
    return ir ? (d << 4) : (d << 3);
  endfunction

endpackage

// File: rtl/jtag_bit_engine.sv
// TCK generator and single LSB-first bit-stream scanner (<= 64 bits).
// tms/tdi update as TCK falls; tdo is sampled as TCK rises.
module jtag_bit_engine
  import dm::*;
#(
  parameter int unsigned ClkDiv = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [6:0]  len_i,
  input  logic [63:0] tms_i,
  input  logic [63:0] tdi_i,
  output logic [63:0] tdo_o,
  output logic        done_o,
  output logic        tck_o,
  output logic        tms_o,
  output logic        tdi_o,
  input  logic        tdo_i
);

  localparam int unsigned DivW = $clog2(ClkDiv);
  localparam logic [DivW-1:0] DivMax = DivW'(ClkDiv - 1);

  logic            act_q, act_d;
  logic            tck_q, tck_d;
  logic            tms_q, tms_d;
  logic            tdi_q, tdi_d;
  logic            done_q, done_d;
  logic [DivW-1:0] div_q, div_d;
  logic [5:0]      idx_q, idx_d;
  logic [5:0]      last_q, last_d;
  logic [63:0]     tms_sr_q, tms_sr_d;
  logic [63:0]     tdi_sr_q, tdi_sr_d;
  logic [63:0]     tdo_q, tdo_d;

  always_comb begin
    act_d = act_q;
    tck_d = tck_q;
    tms_d = tms_q;
    tdi_d = tdi_q;
    done_d = 1'b0;
    div_d = div_q;
    idx_d = idx_q;
    last_d = last_q;
    tms_sr_d = tms_sr_q;
    tdi_sr_d = tdi_sr_q;
    tdo_d = tdo_q;
    if (!act_q) begin
      if (start_i) begin
        act_d = 1'b1;
        div_d = '0;
        idx_d = '0;
        last_d = 6'(len_i - 7'd1);
        tms_d = tms_i[0];
        tdi_d = tdi_i[0];
        tms_sr_d = tms_i >> 1;
        tdi_sr_d = tdi_i >> 1;
        tdo_d = '0;
      end
    end else begin
      div_d = (div_q == DivMax) ? '0 : DivW'(div_q + 1'b1);
      if (div_q == DivMax) begin
        tck_d = ~tck_q;
        if (!tck_q) begin
          tdo_d[idx_q] = tdo_i;
        end else if (idx_q == last_q) begin
          act_d = 1'b0;
          done_d = 1'b1;
        end else begin
          idx_d = idx_q + 6'd1;
          tms_d = tms_sr_q[0];
          tdi_d = tdi_sr_q[0];
          tms_sr_d = tms_sr_q >> 1;
          tdi_sr_d = tdi_sr_q >> 1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      act_q <= 1'b0;
      tck_q <= 1'b0;
      tms_q <= 1'b1;
      tdi_q <= 1'b0;
      done_q <= 1'b0;
      div_q <= '0;
      idx_q <= '0;
      last_q <= '0;
      tms_sr_q <= '0;
      tdi_sr_q <= '0;
      tdo_q <= '0;
    end else begin
      act_q <= act_d;
      tck_q <= tck_d;
      tms_q <= tms_d;
      tdi_q <= tdi_d;
      done_q <= done_d;
      div_q <= div_d;
      idx_q <= idx_d;
      last_q <= last_d;
      tms_sr_q <= tms_sr_d;
      tdi_sr_q <= tdi_sr_d;
      tdo_q <= tdo_d;
    end
  end

  assign tdo_o = tdo_q;
  assign done_o = done_q;
  assign tck_o = tck_q;
  assign tms_o = tms_q;
  assign tdi_o = tdi_q;

endmodule

// File: rtl/dmi_jtag_host.sv
// JTAG TAP initiator turning DMI requests into DTM scans with busy retry.
// Define DMI_JTAG_HOST_TRST_EN to drive trst_no through reset.
module dmi_jtag_host
  import dm::*;
#(
  parameter int unsigned ClkDiv = 4,
  parameter int unsigned IrLength = 5,
  parameter logic [IrLength-1:0] IrDmiAccess = DtmIrDmiAccess,
  parameter logic [IrLength-1:0] IrDtmcs = DtmIrDtmcs,
  parameter int unsigned IdleCycles = 8,
  parameter int unsigned MaxRetries = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  dm::dmi_req_t  dmi_req_i,
  input  logic          dmi_req_valid_i,
  output logic          dmi_req_ready_o,
  output dm::dmi_resp_t dmi_resp_o,
  output logic          dmi_resp_valid_o,
  input  logic          dmi_resp_ready_i,
  output logic          tck_o,
  output logic          tms_o,
  output logic          tdi_o,
  input  logic          tdo_i,
  output logic          trst_no
);

  localparam int unsigned RetryW = $clog2(MaxRetries + 1);

  localparam logic [6:0] IrLen = 7'(IrLength + 6);
  localparam logic [6:0] DrLen = 7'(DmiScanWidth + 5);
  localparam logic [6:0] CsLen = 7'd37;
  localparam logic [63:0] TmsIr = scan_tms(1'b1, 6'(IrLength));
  localparam logic [63:0] TmsDr = scan_tms(1'b0, 6'(DmiScanWidth));
  localparam logic [63:0] TmsCs = scan_tms(1'b0, 6'd32);
  localparam logic [63:0] TdiSel = scan_tdi(1'b1, 64'(IrDmiAccess));
  localparam logic [63:0] TdiCsIr = scan_tdi(1'b1, 64'(IrDtmcs));
  localparam logic [63:0] TdiCs =
    scan_tdi(1'b0, 64'd1 << DtmcsDmiResetBit);

`ifdef DMI_JTAG_HOST_TRST_EN
  localparam host_state_e RstState = StTrst;
`else
  localparam host_state_e RstState = StTapReset;
`endif

  host_state_e       state_q, state_d;
  logic              run_q, run_d;
  logic [RetryW-1:0] retry_q, retry_d;
  dmi_req_t          req_q, req_d;
  dmi_resp_t         resp_q, resp_d;

  logic        scan_st;
  logic        trst_set;
  logic        eng_start;
  logic [6:0]  eng_len;
  logic [63:0] eng_tms;
  logic [63:0] eng_tdi;
  logic [63:0] eng_tdo;
  logic        eng_done;
  dmi_scan_t   stat;

  assign stat = eng_tdo[DmiScanWidth+2:3];

  always_comb begin
    state_d = state_q;
    run_d = run_q;
    retry_d = retry_q;
    req_d = req_q;
    resp_d = resp_q;
    trst_set = 1'b0;
    eng_start = 1'b0;
    eng_len = '0;
    eng_tms = '0;
    eng_tdi = '0;
    scan_st = 1'b1;
    unique case (state_q)
      StTrst: begin
        eng_len = 7'd2;
        eng_tms = 64'h3;
        if (eng_done) begin
          trst_set = 1'b1;
          state_d = StTapReset;
        end
      end
      StTapReset: begin
        eng_len = 7'd6;
        eng_tms = 64'h1F;
        if (eng_done) state_d = StSelIr;
      end
      StSelIr: begin
        eng_len = IrLen;
        eng_tms = TmsIr;
        eng_tdi = TdiSel;
        if (eng_done) state_d = StIdle;
      end
      StIdle: begin
        scan_st = 1'b0;
        if (dmi_req_valid_i) begin
          req_d = dmi_req_i;
          retry_d = '0;
          state_d = StAccess;
        end
      end
      StAccess: begin
        eng_len = DrLen;
        eng_tms = TmsDr;
        eng_tdi = scan_tdi(1'b0, {23'b0, req_q});
        if (eng_done) state_d = StRunIdle;
      end
      StRunIdle: begin
        eng_len = 7'(IdleCycles);
        if (eng_done) state_d = StStatus;
      end
      StStatus: begin
        eng_len = DrLen;
        eng_tms = TmsDr;
        eng_tdi = scan_tdi(1'b0, {23'b0, req_q.addr, 32'b0, DtmNop});
        if (eng_done) begin
          if (stat.op == DtmBusy && retry_q < RetryW'(MaxRetries)) begin
            retry_d = RetryW'(retry_q + 1'b1);
            state_d = StRstIr;
          end else begin
            resp_d = {stat.data, stat.op};
            state_d = StRespond;
          end
        end
      end
      StRstIr: begin
        eng_len = IrLen;
        eng_tms = TmsIr;
        eng_tdi = TdiCsIr;
        if (eng_done) state_d = StRstDr;
      end
      StRstDr: begin
        eng_len = CsLen;
        eng_tms = TmsCs;
        eng_tdi = TdiCs;
        if (eng_done) state_d = StRstSel;
      end
      StRstSel: begin
        eng_len = IrLen;
        eng_tms = TmsIr;
        eng_tdi = TdiSel;
        if (eng_done) state_d = StAccess;
      end
      StRespond: begin
        scan_st = 1'b0;
        if (dmi_resp_ready_i) state_d = StIdle;
      end
      default: begin
        scan_st = 1'b0;
        state_d = RstState;
      end
    endcase
    // each scan state issues exactly one engine run
    if (scan_st) begin
      eng_start = ~run_q;
      run_d = run_q ? ~eng_done : 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RstState;
      run_q <= 1'b0;
      retry_q <= '0;
      req_q <= '0;
      resp_q <= '0;
    end else begin
      state_q <= state_d;
      run_q <= run_d;
      retry_q <= retry_d;
      req_q <= req_d;
      resp_q <= resp_d;
    end
  end

  assign dmi_req_ready_o = (state_q == StIdle);
  assign dmi_resp_valid_o = (state_q == StRespond);
  assign dmi_resp_o = resp_q;

`ifdef DMI_JTAG_HOST_TRST_EN
  logic trst_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) trst_q <= 1'b0;
    else if (trst_set) trst_q <= 1'b1;
  end
  assign trst_no = trst_q;
`else
  logic unused_trst;
  assign unused_trst = trst_set;
  assign trst_no = 1'b1;
`endif

  logic unused_tdo;
  assign unused_tdo = ^{eng_tdo[63:DmiScanWidth+3], eng_tdo[2:0]};

  jtag_bit_engine #(
    .ClkDiv(ClkDiv)
  ) u_engine (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .start_i(eng_start),
    .len_i  (eng_len),
    .tms_i  (eng_tms),
    .tdi_i  (eng_tdi),
    .tdo_o  (eng_tdo),
    .done_o (eng_done),
    .tck_o  (tck_o),
    .tms_o  (tms_o),
    .tdi_o  (tdi_o),
    .tdo_i  (tdo_i)
  );

endmodule

// File: tb/tb_dmi_jtag_host.sv
// Directed bench for dmi_jtag_host against a behavioural TAP/DTM model.
module tb_dmi_jtag_host;
  import dm::*;

  localparam int unsigned ClkDiv = 2;
  localparam int unsigned IdleCycles = 8;
  localparam int unsigned MaxRetries = 4;
  localparam int Bound = 10000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  dmi_req_t req = '0;
  logic req_valid = 1'b0;
  logic req_ready;
  dmi_resp_t resp;
  logic resp_valid;
  logic resp_ready = 1'b0;
  logic tck, tms, tdi, trst_n;
  logic tdo = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dmi_jtag_host #(
    .ClkDiv(ClkDiv),
    .IrLength(5),
    .IrDmiAccess(5'h11),
    .IrDtmcs(5'h10),
    .IdleCycles(IdleCycles),
    .MaxRetries(MaxRetries)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .dmi_req_i(req),
    .dmi_req_valid_i(req_valid),
    .dmi_req_ready_o(req_ready),
    .dmi_resp_o(resp),
    .dmi_resp_valid_o(resp_valid),
    .dmi_resp_ready_i(resp_ready),
    .tck_o(tck),
    .tms_o(tms),
    .tdi_o(tdi),
    .tdo_i(tdo),
    .trst_no(trst_n)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // remote TAP + DTM model
  typedef enum logic [3:0] {
    TLR, RTI, SDS, CDR, SHDR, E1DR, PDR, E2DR, UDR,
    SIS, CIR, SHIR, E1IR, PIR, E2IR, UIR
  } tap_e;

  function automatic tap_e tap_nxt(input tap_e s, input logic m);
    case (s)
      TLR:  return m ? TLR : RTI;
      RTI:  return m ? SDS : RTI;
      SDS:  return m ? SIS : CDR;
      CDR:  return m ? E1DR : SHDR;
      SHDR: return m ? E1DR : SHDR;
      E1DR: return m ? UDR : PDR;
      PDR:  return m ? E2DR : PDR;
      E2DR: return m ? UDR : SHDR;
      UDR:  return m ? SDS : RTI;
      SIS:  return m ? TLR : CIR;
      CIR:  return m ? E1IR : SHIR;
      SHIR: return m ? E1IR : SHIR;
      E1IR: return m ? UIR : PIR;
      PIR:  return m ? E2IR : PIR;
      E2IR: return m ? UIR : SHIR;
      default: return m ? SDS : RTI;
    endcase
  endfunction

  int cfg_busy = 0;
  logic [31:0] cfg_mem = '0;
  int cfg_gen = 0;

  tap_e tap = TLR;
  logic [4:0] ir = 5'h01;
  logic [4:0] ir_sr = '0;
  logic [40:0] dr_sr = '0;
  logic sticky = 1'b0;
  int busy_left = 0;
  int seen_gen = 0;
  logic [6:0] m_addr = '0;
  logic [31:0] m_rdata = '0;
  logic [40:0] acc_val = '0;
  logic [6:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  int n_rst = 0;
  int n_irupd = 0;
  int rti_cnt = 0;
  int rti_at_cap = 0;

  always @(posedge tck) begin
    if (cfg_gen != seen_gen) begin
      seen_gen = cfg_gen;
      busy_left = cfg_busy;
      sticky = 1'b0;
    end
    case (tap)
      TLR: ir = 5'h01;
      RTI: rti_cnt++;
      CDR: begin
        if (ir == 5'h11) begin
          dr_sr = {m_addr, m_rdata, sticky ? 2'b11 : 2'b00};
          rti_at_cap = rti_cnt;
        end else if (ir == 5'h10) dr_sr = 41'h71;
        else dr_sr = '0;
      end
      SHDR: begin
        if (ir == 5'h11) dr_sr = {tdi, dr_sr[40:1]};
        else if (ir == 5'h10) dr_sr = {9'b0, tdi, dr_sr[31:1]};
        else dr_sr = {40'b0, tdi};
      end
      UDR: begin
        rti_cnt = 0;
        if (ir == 5'h11 && !sticky && dr_sr[1:0] != 2'b00) begin
          acc_val = dr_sr;
          if (busy_left > 0) begin
            busy_left--;
            sticky = 1'b1;
          end else if (dr_sr[1:0] == 2'b01) begin
            m_addr = dr_sr[40:34];
            m_rdata = cfg_mem;
          end else if (dr_sr[1:0] == 2'b10) begin
            m_addr = dr_sr[40:34];
            wr_addr = dr_sr[40:34];
            wr_data = dr_sr[33:2];
          end
        end
        if (ir == 5'h10 && dr_sr[16]) begin
          n_rst++;
          sticky = 1'b0;
        end
      end
      CIR: ir_sr = 5'b00001;
      SHIR: ir_sr = {tdi, ir_sr[4:1]};
      UIR: begin
        ir = ir_sr;
        n_irupd++;
      end
      default: ;
    endcase
    tap = tap_nxt(tap, tms);
  end

  always @(negedge tck)
    tdo = (tap == SHDR) ? dr_sr[0] : (tap == SHIR) ? ir_sr[0] : 1'b0;

  int tms1_cnt = 0;
  logic seen0 = 1'b0;
  always @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      tms1_cnt <= 0;
      seen0 <= 1'b0;
    end else if (!seen0) begin
      if (tms) tms1_cnt <= tms1_cnt + 1;
      else seen0 <= 1'b1;
    end
  end

  task automatic wait_ready(input string tag);
    for (int i = 0; i < Bound; i++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    chk(tag, req_ready, 1'b1);
  endtask

  task automatic send_req(input logic [6:0] a, input logic [31:0] d,
                          input logic [1:0] o);
    wait_ready("req_ready");
    req = '{addr: a, data: d, op: o};
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic get_resp(output dmi_resp_t r, input int hold);
    logic stable;
    logic rdy_seen;
    for (int i = 0; i < Bound; i++) begin
      if (resp_valid) break;
      @(negedge clk);
    end
    chk("resp_valid", resp_valid, 1'b1);
    r = resp;
    if (hold > 0) begin
      stable = 1'b1;
      rdy_seen = 1'b0;
      repeat (hold) begin
        @(negedge clk);
        if (resp !== r || !resp_valid) stable = 1'b0;
        if (req_ready) rdy_seen = 1'b1;
      end
      chk("hold_stable", stable, 1'b1);
      chk("hold_no_ready", rdy_seen, 1'b0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("valid_drop", resp_valid, 1'b0);
  endtask

  task automatic do_req(input logic [6:0] a, input logic [31:0] d,
                        input logic [1:0] o, output dmi_resp_t r);
    send_req(a, d, o);
    get_resp(r, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    dmi_resp_t r;
    int base;
    int ok;
    repeat (3) @(negedge clk);
    chk("rst_tck", tck, 1'b0);
    chk("rst_tms", tms, 1'b1);
    chk("rst_tdi", tdi, 1'b0);
    chk("rst_trst", trst_n, 1'b1);
    chk("rst_ready", req_ready, 1'b0);
    chk("rst_valid", resp_valid, 1'b0);
    chk("rst_resp", resp, 34'h0);

    rst_n = 1'b1;
    wait_ready("boot_ready");
    chk("boot_tms1", tms1_cnt, 5);
    chk("boot_ir", ir, 5'h11);
    chk("boot_irupd", n_irupd, 1);

    cfg_mem = 32'hDEADBEEF;
    cfg_busy = 0;
    cfg_gen++;
    do_req(7'h11, 32'h0, 2'b01, r);
    chk("rd_data", r.data, 32'hDEADBEEF);
    chk("rd_resp", r.resp, 2'd0);
    chk("rd_tdi", acc_val, {7'h11, 32'h0, 2'b01});

    do_req(7'h10, 32'h1, 2'b10, r);
    chk("wr_tdi", acc_val, {7'h10, 32'h1, 2'b10});
    chk("wr_addr", wr_addr, 7'h10);
    chk("wr_data", wr_data, 32'h1);
    chk("wr_resp", r.resp, 2'd0);
    chk("wr_idle", rti_at_cap, IdleCycles + 1);

    do_req(7'h22, 32'h0, 2'b00, r);
    chk("nop_resp", r.resp, 2'd0);

    cfg_mem = 32'h12345678;
    cfg_busy = 2;
    cfg_gen++;
    base = n_rst;
    do_req(7'h05, 32'h0, 2'b01, r);
    chk("busy2_resets", n_rst - base, 2);
    chk("busy2_resp", r.resp, 2'd0);
    chk("busy2_data", r.data, 32'h12345678);

    cfg_busy = 0;
    cfg_gen++;
    send_req(7'h11, 32'h0, 2'b01);
    get_resp(r, 20);
    chk("hold_data", r.data, 32'h12345678);
    chk("hold_resp", r.resp, 2'd0);

    cfg_busy = 1000;
    cfg_gen++;
    base = n_rst;
    do_req(7'h07, 32'h0, 2'b01, r);
    chk("busyall_resets", n_rst - base, MaxRetries);
    chk("busyall_resp", r.resp, 2'd3);

    cfg_busy = 0;
    cfg_gen++;
    send_req(7'h11, 32'h0, 2'b01);
    ok = 0;
    for (int i = 0; i < Bound; i++) begin
      @(negedge clk);
      if (tap == SHDR && ir == 5'h11) begin
        ok = 1;
        break;
      end
    end
    chk("mid_reach", ok, 1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_tck", tck, 1'b0);
    chk("mid_tms", tms, 1'b1);
    chk("mid_ready", req_ready, 1'b0);
    repeat (2) @(negedge clk);
    base = n_irupd;
    rst_n = 1'b1;
    wait_ready("mid_boot_ready");
    chk("mid_tms1", tms1_cnt, 5);
    chk("mid_irupd", n_irupd - base, 1);
    chk("mid_ir", ir, 5'h11);

    do_req(7'h11, 32'h0, 2'b01, r);
    chk("post_data", r.data, 32'h12345678);
    chk("post_resp", r.resp, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
